// File: rtl/wait_state_memory.sv
// Single-port word memory with programmable wait states and a one-cycle ready pulse.
// Optional WAIT_STATE_MEMORY_MISALIGN_EN flags and suppresses accesses with addr[1:0] != 0.
module wait_state_memory #(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
    ,
    output logic        misalign
`endif
);

    localparam int AW = $clog2(DEPTH);

    // state | meaning
    // IDLE  | waiting for req
    // WAIT  | counting wait states
    // RESP  | ready pulse; array access happened on the entering edge
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [3:0]      cnt, cnt_next;
    logic            lat_we;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            enter_resp;
    logic            acc_we;
    logic            acc_mis;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            unused_addr;

    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    assign accept     = (state == IDLE) && req;
    assign enter_resp = (state_next == RESP) && (state != RESP);

    // With zero wait states the access completes on the accepting edge, so use the live inputs.
    assign acc_we    = (state == IDLE) ? we               : lat_we;
    assign acc_idx   = (state == IDLE) ? addr[AW+1:2]     : lat_idx;
    assign acc_wdata = (state == IDLE) ? wdata            : lat_wdata;

`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
    logic lat_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_mis <= 1'b0;
        end else if (accept) begin
            lat_mis <= (addr[1:0] != 2'b00);
        end
    end

    assign acc_mis  = (state == IDLE) ? (addr[1:0] != 2'b00) : lat_mis;
    assign misalign = (state == RESP) && lat_mis;
`else
    assign acc_mis = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'h0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we    <= we;
                lat_idx   <= addr[AW+1:2];
                lat_wdata <= wdata;
            end
            if (enter_resp && !acc_we) begin
                rdata <= acc_mis ? 32'h0 : mem[acc_idx];
            end
        end
    end

    // Gated by reset so an access aborted on its final edge never lands in the array.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_we && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_wait_state_memory.sv
// Drives one slow (2 wait states) and one fast (0 wait states) memory with the same stimulus.
module tb_wait_state_memory;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, busy2, busy0;
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
    logic        mis2, mis0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp2;
        logic [31:0] exp0;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    wait_state_memory #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .busy(busy2)
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
        , .misalign(mis2)
`endif
    );

    wait_state_memory #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .busy(busy0)
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
        , .misalign(mis0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One access; inputs are scrambled after acceptance to prove the latched copies are used.
    task automatic do_acc(input vec_t v);
        int lat2 = 0, lat0 = 0, nr2 = 0, nr0 = 0;
        logic [31:0] rd2 = 32'hx, rd0 = 32'hx;
        logic m2 = 1'b0, m0 = 1'b0;
        @(negedge clk);
        req = 1'b1; we = v.w; addr = v.a; wdata = v.d;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 1'b0; we = ~v.w; addr = v.a ^ 32'h44; wdata = ~v.d;
            end
            if (ready2) begin
                nr2++; lat2 = k; rd2 = rdata2;
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
                m2 = mis2;
`endif
            end
            if (ready0) begin
                nr0++; lat0 = k; rd0 = rdata0;
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
                m0 = mis0;
`endif
            end
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
            if (!ready2) check("misalign_quiet_slow", 32'(mis2), 32'd0);
`endif
        end
        check("latency_slow", lat2, 32'd3);
        check("latency_fast", lat0, 32'd1);
        check("pulses_slow", nr2, 32'd1);
        check("pulses_fast", nr0, 32'd1);
        check("rdata_slow", rd2, v.exp2);
        check("rdata_fast", rd0, v.exp0);
`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
        check("misalign_slow", 32'(m2), 32'(v.mis));
        check("misalign_fast", 32'(m0), 32'(v.mis));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] er2, eb2, er0, eb0;

        // Reset with req held: nothing may be accepted.
        reset = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h0BADF00D;
        repeat (2) begin
            @(negedge clk);
            check("reset_ready_slow", 32'(ready2), 32'd0);
            check("reset_busy_slow", 32'(busy2), 32'd0);
            check("reset_rdata_slow", rdata2, 32'h0);
            check("reset_ready_fast", 32'(ready0), 32'd0);
            check("reset_busy_fast", 32'(busy0), 32'd0);
            check("reset_rdata_fast", rdata0, 32'h0);
        end
        reset = 1'b0; req = 1'b0;
        @(negedge clk);
        check("post_reset_busy_slow", 32'(busy2), 32'd0);
        check("post_reset_busy_fast", 32'(busy0), 32'd0);

        tbl.push_back(vec_t'{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h0000_0400, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001, 32'h0000_0001, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0001, 32'h0000_0001, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 32'h1234_5678, 32'h1234_5678, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0000_0414, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'hFFFF_FC10, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        foreach (tbl[i]) do_acc(tbl[i]);

        // req held high: slow accepts every 4 cycles, fast every 2.
        er2 = 8'h44; eb2 = 8'h77; er0 = 8'h55; eb0 = 8'h55;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("b2b_ready_slow", 32'(ready2), 32'(er2[k-1]));
            check("b2b_busy_slow", 32'(busy2), 32'(eb2[k-1]));
            check("b2b_ready_fast", 32'(ready0), 32'(er0[k-1]));
            check("b2b_busy_fast", 32'(busy0), 32'(eb0[k-1]));
            if (ready2) check("b2b_rdata_slow", rdata2, 32'hDEAD_BEEF);
            if (ready0) check("b2b_rdata_fast", rdata0, 32'hDEAD_BEEF);
            if (k == 7) req = 1'b0;
        end

        // Reset on the slow memory's final wait edge: its write must be discarded.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("abort_ready_slow", 32'(ready2), 32'd0);
            if (k == 1) req = 1'b0;
            if (k == 2) reset = 1'b1;
            if (k == 3) begin
                check("abort_busy_slow", 32'(busy2), 32'd0);
                check("abort_rdata_slow", rdata2, 32'h0);
                check("abort_rdata_fast", rdata0, 32'h0);
                reset = 1'b0;
            end
        end
        do_acc(vec_t'{1'b0, 32'h20, 32'h0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0});

`ifdef WAIT_STATE_MEMORY_MISALIGN_EN
        do_acc(vec_t'{1'b1, 32'h22, 32'hBAD0_BAD0, 32'h1234_5678, 32'hCAFE_F00D, 1'b1});
        do_acc(vec_t'{1'b0, 32'h23, 32'h0,         32'h0000_0000, 32'h0000_0000, 1'b1});
        do_acc(vec_t'{1'b0, 32'h20, 32'h0,         32'h1234_5678, 32'hCAFE_F00D, 1'b0});
`else
        do_acc(vec_t'{1'b1, 32'h33, 32'h55AA_55AA, 32'h1234_5678, 32'hCAFE_F00D, 1'b0});
        do_acc(vec_t'{1'b0, 32'h30, 32'h0,         32'h55AA_55AA, 32'h55AA_55AA, 1'b0});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
